// File: rtl/unified_load_logic.sv
// Read-side sequencer for one butterfly stage: walks all operand pairs and issues
// conflict-free reads to the two ping-pong banks. It un-swaps the returned words into
// a/b operands and forwards the in-place destination of each operand.
module unified_load_logic #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned STAGE_W    = 4,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned LOGQ       = 54,
  parameter int unsigned BRAM_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [STAGE_W-1:0]    stage,
  input  logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic                  rea,
  input  logic [DATA_W-1:0]     data_from_bram_0,
  input  logic [DATA_W-1:0]     data_from_bram_1,
  input  logic [LOGQ-1:0]       data_from_bram_2,
  input  logic [LOGQ-1:0]       data_from_bram_3,
  input  logic [LOGQ-1:0]       data_from_bram_4,
  input  logic [LOGQ-1:0]       data_from_bram_5,
  output logic [DATA_W-1:0]     a_data,
  output logic [DATA_W-1:0]     b_data,
  output logic [LOGQ-1:0]       a_data_1,
  output logic [LOGQ-1:0]       b_data_1,
  output logic [LOGQ-1:0]       a_data_2,
  output logic [LOGQ-1:0]       b_data_2,
  output logic                  valid,
  output logic                  dest_bank_a,
  output logic                  dest_bank_b,
  output logic [ADDR_WIDTH-1:0] dest_addr_a,
  output logic [ADDR_WIDTH-1:0] dest_addr_b
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  // Per-read tag travelling alongside the BRAM access; bank_i doubles as the swap flag.
  typedef struct packed {
    logic                  issued;
    logic                  bank_i;
    logic                  bank_j;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [ADDR_WIDTH-1:0] addr_j;
  } tag_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d, k_cur;
  logic [STAGE_W-1:0]    s_q, s_d, s_cur;
  logic                  done_q, done_d;
  logic                  issue, stage_ok, pipe_busy;

  logic [ADDR_WIDTH:0]   k_ext, span, low_mask, idx_i, idx_j;
  logic                  bank_i, bank_j;
  logic [ADDR_WIDTH-1:0] addr_i, addr_j;

  logic                  rea_q;
  logic [ADDR_WIDTH-1:0] ra0_q, ra1_q;
  tag_t                  tag_new;
  tag_t                  tag_q [BRAM_LAT+1];

  logic                  valid_q, dbank_a_q, dbank_b_q;
  logic [ADDR_WIDTH-1:0] daddr_a_q, daddr_b_q;
  logic [DATA_W-1:0]     a_q, b_q;
  logic [LOGQ-1:0]       a1_q, b1_q, a2_q, b2_q;

  assign stage_ok = (32'(stage) <= ADDR_WIDTH);

  // In IDLE the pair about to issue is k=0 of the requested stage, so a start with en high
  // issues its first read on the accepting edge.
  always_comb begin
    k_cur = k_q;
    s_cur = s_q;
    if (state_q == StIdle) begin
      k_cur = '0;
      s_cur = stage;
    end
  end

  // Pair index to element indices: insert a zero at bit s for i; j sets that bit.
  always_comb begin
    k_ext    = {1'b0, k_cur};
    span     = {{ADDR_WIDTH{1'b0}}, 1'b1} << s_cur;
    low_mask = span - (ADDR_WIDTH+1)'(1);
    idx_i    = (k_ext & low_mask) | ((k_ext & ~low_mask) << 1);
    idx_j    = idx_i | span;
    bank_i   = ^idx_i;
    bank_j   = ^idx_j;
    addr_i   = idx_i[ADDR_WIDTH:1];
    addr_j   = idx_j[ADDR_WIDTH:1];
  end

  // Any read still travelling through the latency pipe.
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned n = 0; n <= BRAM_LAT; n++) begin
      pipe_busy = pipe_busy | tag_q[n].issued;
    end
  end

  // Next-state logic: issue one pair per enabled cycle, then drain the read pipe.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && stage_ok) begin
          s_d     = stage;
          k_d     = '0;
          state_d = StIssue;
          if (en) begin
            issue = 1'b1;
            k_d   = k_cur + ADDR_WIDTH'(1);
            if (&k_cur) state_d = StDrain;
          end
        end
      end
      StIssue: begin
        if (en) begin
          issue = 1'b1;
          k_d   = k_q + ADDR_WIDTH'(1);
          if (&k_q) state_d = StDrain;
        end
      end
      StDrain: begin
        // The last valid is on the outputs once the pipe is empty; done follows it.
        if (!pipe_busy) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, pair counter and stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  // Read request registers; addresses hold while issuing is paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rea_q <= 1'b0;
      ra0_q <= '0;
      ra1_q <= '0;
    end else begin
      rea_q <= issue;
      if (issue) begin
        ra0_q <= bank_i ? addr_j : addr_i;
        ra1_q <= bank_i ? addr_i : addr_j;
      end
    end
  end

  always_comb begin
    tag_new        = '0;
    tag_new.issued = issue;
    tag_new.bank_i = bank_i;
    tag_new.bank_j = bank_j;
    tag_new.addr_i = addr_i;
    tag_new.addr_j = addr_j;
  end

  // Tag delay line: entry 0 accompanies rea, entry BRAM_LAT lines up with read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n <= BRAM_LAT; n++) tag_q[n] <= '0;
    end else begin
      tag_q[0] <= tag_new;
      for (int unsigned n = 1; n <= BRAM_LAT; n++) tag_q[n] <= tag_q[n-1];
    end
  end

  // Output register: un-swap bank data into a/b operands and forward destinations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      dbank_a_q <= 1'b0;
      dbank_b_q <= 1'b0;
      daddr_a_q <= '0;
      daddr_b_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a1_q      <= '0;
      b1_q      <= '0;
      a2_q      <= '0;
      b2_q      <= '0;
    end else begin
      valid_q <= tag_q[BRAM_LAT].issued;
      if (tag_q[BRAM_LAT].issued) begin
        dbank_a_q <= tag_q[BRAM_LAT].bank_i;
        dbank_b_q <= tag_q[BRAM_LAT].bank_j;
        daddr_a_q <= tag_q[BRAM_LAT].addr_i;
        daddr_b_q <= tag_q[BRAM_LAT].addr_j;
        if (tag_q[BRAM_LAT].bank_i) begin
          a_q  <= data_from_bram_1;
          b_q  <= data_from_bram_0;
          a1_q <= data_from_bram_3;
          b1_q <= data_from_bram_2;
          a2_q <= data_from_bram_5;
          b2_q <= data_from_bram_4;
        end else begin
          a_q  <= data_from_bram_0;
          b_q  <= data_from_bram_1;
          a1_q <= data_from_bram_2;
          b1_q <= data_from_bram_3;
          a2_q <= data_from_bram_4;
          b2_q <= data_from_bram_5;
        end
      end
    end
  end

  // busy stays high through the done cycle even though the FSM is already idle.
  assign busy        = (state_q != StIdle) | done_q;
  assign done        = done_q;
  assign rea         = rea_q;
  assign read_addr_0 = ra0_q;
  assign read_addr_1 = ra1_q;
  assign valid       = valid_q;
  assign dest_bank_a = dbank_a_q;
  assign dest_bank_b = dbank_b_q;
  assign dest_addr_a = daddr_a_q;
  assign dest_addr_b = daddr_b_q;
  assign a_data      = a_q;
  assign b_data      = b_q;
  assign a_data_1    = a1_q;
  assign b_data_1    = b1_q;
  assign a_data_2    = a2_q;
  assign b_data_2    = b2_q;

endmodule

// File: tb/tb_unified_load_logic.sv
// Directed bench for unified_load_logic with ADDR_WIDTH=3, BRAM_LAT=2 and a BRAM model in
// which bank b at address a holds element x with bank(x)=b, addr(x)=a.
module tb_unified_load_logic;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 128;
  localparam int unsigned LW = 54;
  localparam int unsigned RW = 2*DW + 4*LW + 2 + 2*AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    stage = '0;
  logic          en = 1'b0;
  logic          busy, done, rea, valid;
  logic [AW-1:0] read_addr_0, read_addr_1, dest_addr_a, dest_addr_b;
  logic          dest_bank_a, dest_bank_b;
  logic [DW-1:0] d0, d1, a_data, b_data;
  logic [LW-1:0] d2, d3, d4, d5, a_data_1, b_data_1, a_data_2, b_data_2;
  logic [RW-1:0] mon_rec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [RW-1:0] vq[$];
  int            vcyc[$];
  int            reaq[$];
  int            doneq[$];

  unified_load_logic #(
    .ADDR_WIDTH(AW), .STAGE_W(4), .DATA_W(DW), .LOGQ(LW), .BRAM_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .en(en),
    .busy(busy), .done(done),
    .read_addr_0(read_addr_0), .read_addr_1(read_addr_1), .rea(rea),
    .data_from_bram_0(d0), .data_from_bram_1(d1), .data_from_bram_2(d2),
    .data_from_bram_3(d3), .data_from_bram_4(d4), .data_from_bram_5(d5),
    .a_data(a_data), .b_data(b_data), .a_data_1(a_data_1), .b_data_1(b_data_1),
    .a_data_2(a_data_2), .b_data_2(b_data_2), .valid(valid),
    .dest_bank_a(dest_bank_a), .dest_bank_b(dest_bank_b),
    .dest_addr_a(dest_addr_a), .dest_addr_b(dest_addr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] w128(int b, int x);
    return {b[7:0], 112'h5A5A, x[7:0]};
  endfunction

  function automatic logic [LW-1:0] w54(int b, int x);
    return {b[7:0], 38'h2A_5555_AAAA, x[7:0]};
  endfunction

  // Element stored in bank b at address a.
  function automatic int elem(int b, logic [AW-1:0] a);
    logic lsb;
    lsb = b[0] ^ (^a);
    return int'({a, lsb});
  endfunction

  // Two-cycle BRAM model.
  logic [AW-1:0] ra0_d1, ra0_d2, ra1_d1, ra1_d2;
  always @(posedge clk) begin
    ra0_d1 <= read_addr_0;
    ra0_d2 <= ra0_d1;
    ra1_d1 <= read_addr_1;
    ra1_d2 <= ra1_d1;
  end
  assign d0 = w128(0, elem(0, ra0_d2));
  assign d1 = w128(1, elem(1, ra1_d2));
  assign d2 = w54(2, elem(0, ra0_d2));
  assign d3 = w54(3, elem(1, ra1_d2));
  assign d4 = w54(4, elem(0, ra0_d2));
  assign d5 = w54(5, elem(1, ra1_d2));

  assign mon_rec = {a_data, b_data, a_data_1, b_data_1, a_data_2, b_data_2,
                    dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b};

  // Expected output record for pair k of stage s.
  function automatic logic [RW-1:0] exp_rec(int k, int s);
    int i, j;
    logic [3:0] xi, xj;
    logic bi, bj;
    i  = ((k >> s) << (s + 1)) | (k & ((1 << s) - 1));
    j  = i + (1 << s);
    xi = i[3:0];
    xj = j[3:0];
    bi = ^xi;
    bj = ^xj;
    return {w128(int'(bi), i), w128(int'(bj), j),
            w54(2 + int'(bi), i), w54(2 + int'(bj), j),
            w54(4 + int'(bi), i), w54(4 + int'(bj), j),
            bi, bj, xi[3:1], xj[3:1]};
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(mon_rec);
      vcyc.push_back(cyc);
    end
    if (rea) reaq.push_back(cyc);
    if (done) doneq.push_back(cyc);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    vq.delete();
    vcyc.delete();
    reaq.delete();
    doneq.delete();
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, valid, rea} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, valid, rea});
    end
    checks++;
    if ({read_addr_0, read_addr_1} !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", {read_addr_0, read_addr_1});
    end
    checks++;
    if (mon_rec !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", mon_rec);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_stage0_pairs;
    bit to;
    stage = 4'd0; en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    checks++;
    if ({busy, rea, read_addr_0, read_addr_1} !== {1'b1, 1'b1, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL s0_k0_issue got=%b exp=11_000_000", {busy, rea, read_addr_0, read_addr_1});
    end
    tick();
    checks++;
    if ({rea, read_addr_0, read_addr_1} !== {1'b1, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL s0_k1_issue got=%b exp=1_001_001", {rea, read_addr_0, read_addr_1});
    end
    tick(); tick();
    checks++;
    if ({valid, dest_bank_a, dest_bank_b} !== 3'b101) begin
      failures++;
      $display("FAIL s0_k0_valid got=%b exp=101", {valid, dest_bank_a, dest_bank_b});
    end
    checks++;
    if (a_data !== w128(0, 0) || b_data !== w128(1, 1)) begin
      failures++;
      $display("FAIL s0_k0_data got a=%h b=%h", a_data, b_data);
    end
    tick();
    checks++;
    if ({valid, dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b} !== {3'b110, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL s0_k1_dest got=%b exp=110_001_001",
               {valid, dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b});
    end
    checks++;
    if (a_data !== w128(1, 2) || b_data !== w128(0, 3) || a_data_1 !== w54(3, 2)) begin
      failures++;
      $display("FAIL s0_k1_swap got a=%h b=%h a1=%h", a_data, b_data, a_data_1);
    end
    wait_idle(to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL s0_idle_timeout got=busy exp=idle");
    end
  endtask

  task automatic test_pair5_stage2;
    bit to;
    stage = 4'd2; en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    checks++;
    if ({rea, read_addr_0, read_addr_1} !== {1'b1, 3'd4, 3'd6}) begin
      failures++;
      $display("FAIL s2_k5_issue got=%b exp=1_100_110", {rea, read_addr_0, read_addr_1});
    end
    repeat (3) tick();
    checks++;
    if ({valid, dest_bank_a, dest_addr_a, dest_bank_b, dest_addr_b} !== {1'b1, 1'b0, 3'd4, 1'b1, 3'd6})
    begin
      failures++;
      $display("FAIL s2_k5_dest got=%b exp=1_0_100_1_110",
               {valid, dest_bank_a, dest_addr_a, dest_bank_b, dest_addr_b});
    end
    checks++;
    if (a_data !== w128(0, 9) || b_data !== w128(1, 13) || b_data_2 !== w54(5, 13)) begin
      failures++;
      $display("FAIL s2_k5_data got a=%h b=%h b2=%h", a_data, b_data, b_data_2);
    end
    wait_idle(to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL s2_idle_timeout got=busy exp=idle");
    end
  endtask

  task automatic test_full_stage;
    int t0;
    bit got_done;
    clear_mon();
    stage = 4'd3; en = 1'b1; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    got_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got_done || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_done_busy got done=%b busy=%b exp done=1 busy=1", got_done, busy);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL full_after_done got=%b exp=00", {busy, done});
    end
    checks++;
    if (vq.size() != 8) begin
      failures++;
      $display("FAIL full_count got=%0d exp=8", vq.size());
    end
    for (int idx = 0; idx < vq.size() && idx < 8; idx++) begin
      checks++;
      if (vq[idx] !== exp_rec(idx, 3) || vcyc[idx] != t0 + 4 + idx) begin
        failures++;
        $display("FAIL full_pair[%0d] got=%h @%0d exp=%h @%0d", idx, vq[idx], vcyc[idx],
                 exp_rec(idx, 3), t0 + 4 + idx);
      end
    end
    checks++;
    if (doneq.size() != 1 || doneq[0] != t0 + 12) begin
      failures++;
      $display("FAIL full_done_cycle got n=%0d exp n=1 at %0d", doneq.size(), t0 + 12);
    end
  endtask

  task automatic test_en_gaps;
    int t0;
    bit to;
    int pat[15];
    int voff[8];
    pat  = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1};
    voff = '{4, 7, 8, 10, 14, 15, 17, 18};
    clear_mon();
    stage = 4'd1; t0 = cyc;
    for (int c = 0; c < 15; c++) begin
      start = (c == 0);
      en = pat[c][0];
      tick();
    end
    start = 1'b0; en = 1'b0;
    wait_idle(to);
    checks++;
    if (to || vq.size() != 8 || reaq.size() != 8) begin
      failures++;
      $display("FAIL gaps_count got valids=%0d reads=%0d exp=8", vq.size(), reaq.size());
    end
    for (int idx = 0; idx < vq.size() && idx < 8; idx++) begin
      checks++;
      if (vq[idx] !== exp_rec(idx, 1) || vcyc[idx] != t0 + voff[idx] ||
          reaq[idx] != t0 + voff[idx] - 3) begin
        failures++;
        $display("FAIL gaps_pair[%0d] got valid@%0d rea@%0d exp valid@%0d rea@%0d", idx,
                 vcyc[idx], reaq[idx], t0 + voff[idx], t0 + voff[idx] - 3);
      end
    end
    checks++;
    if (doneq.size() != 1 || doneq[0] != t0 + 19) begin
      failures++;
      $display("FAIL gaps_done got n=%0d exp n=1 at %0d", doneq.size(), t0 + 19);
    end
  endtask

  task automatic test_ignored_starts;
    int t0;
    bit to;
    clear_mon();
    stage = 4'd4; en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_stage_busy got=%b exp=0", busy);
    end
    repeat (4) tick();
    checks++;
    if (reaq.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_stage_reads got=%0d exp=0", reaq.size());
    end
    stage = 4'd1; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    tick(); tick();
    stage = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    wait_idle(to);
    checks++;
    if (to || vq.size() != 8 || doneq.size() != 1) begin
      failures++;
      $display("FAIL restart_count got valids=%0d dones=%0d exp 8/1", vq.size(), doneq.size());
    end
    for (int idx = 0; idx < vq.size() && idx < 8; idx++) begin
      checks++;
      if (vq[idx] !== exp_rec(idx, 1) || vcyc[idx] != t0 + 4 + idx) begin
        failures++;
        $display("FAIL restart_pair[%0d] got=%h @%0d exp=%h @%0d", idx, vq[idx], vcyc[idx],
                 exp_rec(idx, 1), t0 + 4 + idx);
      end
    end
  endtask

  task automatic test_reset_midstage;
    int t0;
    bit to;
    clear_mon();
    stage = 4'd3; en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, rea, valid, done, read_addr_0, read_addr_1} !== '0) begin
      failures++;
      $display("FAIL midrst_ctrl got=%b exp=0", {busy, rea, valid, done, read_addr_0, read_addr_1});
    end
    checks++;
    if (mon_rec !== '0) begin
      failures++;
      $display("FAIL midrst_data got=%h exp=0", mon_rec);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    clear_mon();
    repeat (10) tick();
    checks++;
    if (vq.size() != 0 || doneq.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_leak got valids=%0d dones=%0d busy=%b exp 0/0/0", vq.size(),
               doneq.size(), busy);
    end
    clear_mon();
    stage = 4'd2; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    wait_idle(to);
    checks++;
    if (to || vq.size() != 8 || doneq.size() != 1 || doneq[0] != t0 + 12) begin
      failures++;
      $display("FAIL midrst_rerun got valids=%0d dones=%0d exp 8/1 at %0d", vq.size(),
               doneq.size(), t0 + 12);
    end
    for (int idx = 0; idx < vq.size() && idx < 8; idx++) begin
      checks++;
      if (vq[idx] !== exp_rec(idx, 2) || vcyc[idx] != t0 + 4 + idx) begin
        failures++;
        $display("FAIL midrst_pair[%0d] got=%h @%0d exp=%h @%0d", idx, vq[idx], vcyc[idx],
                 exp_rec(idx, 2), t0 + 4 + idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stage0_pairs();
    test_pair5_stage2();
    test_full_stage();
    test_en_gaps();
    test_ignored_starts();
    test_reset_midstage();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
